// File: rtl/pipe_adder_nb_pkg.sv
// Shared configuration helpers for the pipelined adder/subtractor.
// Carry-segment width and the legality rule for the N/STAGES pair live here.
package pipe_adder_nb_pkg;

    function automatic int seg_width(input int n, input int stages);
        return n / stages;
    endfunction

    function automatic bit cfg_ok(input int n, input int stages);
        return (n >= 1) && (stages >= 1) && (n % stages == 0);
    endfunction

endpackage

// File: rtl/pipe_adder_nb_if.sv
// Operand/result stream bundle for pipe_adder_nb.
// The producer/consumer side takes master; the adder takes slave.
interface pipe_adder_nb_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipe_adder_nb_fulladder.sv
// Combinational N-bit segment adder used once per pipeline stage.
// c_msb is the carry into bit N-1, needed for signed overflow on the top segment.
module fulladderNb #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         c_msb
);
    logic [N:0] full;

    assign full  = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    assign sum   = full[N-1:0];
    assign cout  = full[N];
    assign c_msb = a[N-1] ^ b[N-1] ^ full[N-1];
endmodule

// File: rtl/pipe_adder_nb.sv
// Pipelined N-bit adder/subtractor: one carry segment per stage, valid/ready per stage.
// Operands ride the pipe (skew) and finished low segments ride along (de-skew).
module pipe_adder_nb
    import pipe_adder_nb_pkg::*;
#(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input logic           clk,
    input logic           rst,
    pipe_adder_nb_if.slave bus
);
    localparam int SEG = seg_width(N, STAGES);

    if (!cfg_ok(N, STAGES)) begin : g_cfg_err
        $error("pipe_adder_nb: N=%0d must be >=1 and divisible by STAGES=%0d", N, STAGES);
    end

    logic [STAGES-1:0][N-1:0]   a_q, a_d, b_q, b_d, s_q, s_d;
    logic [STAGES-1:0]          v_q, v_d, c_q, c_d;
    logic                       ovf_q, ovf_d;
    logic [STAGES-1:0][N-1:0]   op_a, op_b, part;
    logic [STAGES-1:0]          op_c, op_v, ld;
    logic [STAGES-1:0][SEG-1:0] seg_sum;
    logic [STAGES-1:0]          seg_co, seg_cm;
    logic                       unused_bits;

    // Ready chain: a stage may load if it is empty or its successor moves this cycle.
    always_comb begin
        logic rdy;
        rdy = bus.out_ready;
        ld  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy   = !v_q[k] || rdy;
            ld[k] = rdy;
        end
    end

    always_comb begin
        op_a    = '0;
        op_b    = '0;
        op_c    = '0;
        op_v    = '0;
        part    = '0;
        op_a[0] = bus.a;
        op_b[0] = bus.sub ? ~bus.b : bus.b;
        op_c[0] = bus.sub ^ bus.cin;
        op_v[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            op_a[k] = a_q[k-1];
            op_b[k] = b_q[k-1];
            op_c[k] = c_q[k-1];
            op_v[k] = v_q[k-1];
            part[k] = s_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        fulladderNb #(.N(SEG)) u_seg (
            .a     (op_a[k][k*SEG +: SEG]),
            .b     (op_b[k][k*SEG +: SEG]),
            .cin   (op_c[k]),
            .sum   (seg_sum[k]),
            .cout  (seg_co[k]),
            .c_msb (seg_cm[k])
        );
    end

    // NOTE: every _d starts as its _q so no path through this block can infer a latch.
    always_comb begin
        v_d   = v_q;
        a_d   = a_q;
        b_d   = b_q;
        s_d   = s_q;
        c_d   = c_q;
        ovf_d = ovf_q;
        for (int k = 0; k < STAGES; k++) begin
            if (ld[k]) begin
                v_d[k] = op_v[k];
                if (op_v[k]) begin
                    a_d[k]                 = op_a[k];
                    b_d[k]                 = op_b[k];
                    s_d[k]                 = part[k];
                    s_d[k][k*SEG +: SEG]   = seg_sum[k];
                    c_d[k]                 = seg_co[k];
                end
            end
        end
        if (ld[STAGES-1] && op_v[STAGES-1]) begin
            ovf_d = seg_cm[STAGES-1] ^ seg_co[STAGES-1];
        end
    end

    // NOTE: data registers are reset too, so sum/cout/ovf read 0 straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
            v_q   <= v_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.in_ready  = ld[0];
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.sum       = s_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];
    assign bus.ovf       = ovf_q;

    // Consumed segments of the skewed operands and lower-stage MSB carries are dead by design.
    assign unused_bits = ^{a_q, b_q, seg_cm};
endmodule

// File: tb/tb_pipe_adder_nb.sv
// Scoreboard bench for pipe_adder_nb: arithmetic reference model, queue-based monitor,
// stall/reset scenarios on a 16/4 instance and carry-ripple sweeps on 8/1, 32/8, 12/3.
module tb_pipe_adder_nb;
  localparam int N = 16;
  localparam int S = 4;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
    bit          chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   ready_mode = 1;
  bit   chk_lat_mode = 1'b1;
  bit   sweep_go = 1'b0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  pipe_adder_nb_if #(.N(N)) bus ();
  pipe_adder_nb #(.N(N), .STAGES(S)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain-integer reference: a+b+cin or a-b-cin, modulo 2^n, with carry and signed range test.
  function automatic exp_t model(input int n, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub, input int acc, input bit lat);
    exp_t   e;
    longint m, ai, bi, ci, sgn_a, sgn_b, r, sr;
    m     = longint'(1) << n;
    ai    = longint'(a);
    bi    = longint'(b);
    ci    = cin ? 64'sd1 : 64'sd0;
    sgn_a = (ai >= m / 2) ? ai - m : ai;
    sgn_b = (bi >= m / 2) ? bi - m : bi;
    if (!sub) begin
      r      = ai + bi + ci;
      sr     = sgn_a + sgn_b + ci;
      e.cout = (r >= m);
      e.sum  = 32'(r % m);
    end else begin
      r      = ai - bi - ci;
      sr     = sgn_a - sgn_b - ci;
      e.cout = (r >= 0);
      e.sum  = 32'((r + m) % m);
    end
    e.ovf     = (sr < -(m / 2)) || (sr >= m / 2);
    e.acc     = acc;
    e.chk_lat = lat;
    return e;
  endfunction

  // out_ready driver, applied 2 time units after each rising edge
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: checks ready rule, hold stability, and pops/compares every emitted beat.
  bit          held = 1'b0;
  logic [17:0] held_val;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      held = 1'b0;
    end else begin
      check("in_ready_rule", 64'(bus.in_ready), 64'(!(q.size() == S && !bus.out_ready)));
      if (held) begin
        check("hold_valid", 64'(bus.out_valid), 64'(1));
        check("hold_data", 64'({bus.sum, bus.cout, bus.ovf}), 64'(held_val));
      end
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          check("beat_pending", 64'(q.size() > 0), 64'(1));
          if (q.size() > 0) begin
            e = q.pop_front();
            check("sum", 64'(bus.sum), 64'(e.sum[N-1:0]));
            check("cout", 64'(bus.cout), 64'(e.cout));
            check("ovf", 64'(bus.ovf), 64'(e.ovf));
            if (e.chk_lat) check("latency", 64'(cyc - e.acc), 64'(S));
          end
        end
        held     = !bus.out_ready;
        held_val = {bus.sum, bus.cout, bus.ovf};
      end else begin
        held = 1'b0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic ci, input logic sb);
    bit rdy;
    int acc;
    int w;
    rdy = 1'b0;
    w   = 0;
    bus.in_valid = 1'b1;
    bus.a        = av[N-1:0];
    bus.b        = bv[N-1:0];
    bus.cin      = ci;
    bus.sub      = sb;
    while (!rdy && w < 200) begin
      @(negedge clk);
      rdy = bus.in_ready;
      acc = cyc;
      @(posedge clk);
      if (rdy) q.push_back(model(N, av, bv, ci, sb, acc, chk_lat_mode));
      #1;
      w++;
    end
    check("send_accepted", 64'(rdy), 64'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() > 0 && w < 300) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("drain_empty", 64'(q.size()), 64'(0));
  endtask

  // Carry-ripple sweep over other N/STAGES configurations, out_ready tied high.
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int NW = (g == 0) ? 8 : (g == 1) ? 32 : 12;
    localparam int SW = (g == 0) ? 1 : (g == 1) ? 8 : 3;
    localparam int SG = NW / SW;

    bit   done = 1'b0;
    exp_t sq[$];

    pipe_adder_nb_if #(.N(NW)) swb ();
    pipe_adder_nb #(.N(NW), .STAGES(SW)) dut_sw (.clk(clk), .rst(rst), .bus(swb));

    assign swb.out_ready = 1'b1;

    initial begin : drv
      logic [63:0] mask, av, bv;
      logic        ci, sb;
      bit          rdy;
      int          acc;
      int          w;
      mask = (64'd1 << NW) - 64'd1;
      swb.in_valid = 1'b0;
      swb.a = '0;
      swb.b = '0;
      swb.cin = 1'b0;
      swb.sub = 1'b0;
      wait (sweep_go);
      @(posedge clk);
      #1;
      for (int i = 0; i < SW + 12; i++) begin
        ci = 1'b0;
        sb = 1'b0;
        bv = 64'd1;
        if (i < SW) begin
          av = (64'd1 << ((i + 1) * SG)) - 64'd1;
        end else if (i == SW) begin
          av = mask; bv = 64'd0; ci = 1'b1;
        end else if (i == SW + 1) begin
          av = 64'd0; sb = 1'b1;
        end else if (i == SW + 2) begin
          av = 64'd0; bv = 64'd0; ci = 1'b1; sb = 1'b1;
        end else if (i == SW + 3) begin
          av = 64'd1 << (NW - 1); sb = 1'b1;
        end else begin
          av = {32'd0, $urandom} & mask;
          bv = {32'd0, $urandom} & mask;
          ci = 1'($urandom_range(0, 1));
          sb = 1'($urandom_range(0, 1));
        end
        swb.in_valid = 1'b1;
        swb.a   = av[NW-1:0];
        swb.b   = bv[NW-1:0];
        swb.cin = ci;
        swb.sub = sb;
        @(negedge clk);
        rdy = swb.in_ready;
        acc = cyc;
        check($sformatf("sw%0d_in_ready", g), 64'(rdy), 64'(1));
        @(posedge clk);
        if (rdy) sq.push_back(model(NW, av[31:0], bv[31:0], ci, sb, acc, 1'b1));
        #1;
      end
      swb.in_valid = 1'b0;
      w = 0;
      while (sq.size() > 0 && w < 50) begin
        @(posedge clk);
        w++;
      end
      check($sformatf("sw%0d_drain", g), 64'(sq.size()), 64'(0));
      done = 1'b1;
    end

    always @(negedge clk) begin
      exp_t e;
      if (!rst && swb.out_valid) begin
        check($sformatf("sw%0d_pending", g), 64'(sq.size() > 0), 64'(1));
        if (sq.size() > 0) begin
          e = sq.pop_front();
          check($sformatf("sw%0d_sum", g), 64'(swb.sum), 64'(e.sum[NW-1:0]));
          check($sformatf("sw%0d_cout", g), 64'(swb.cout), 64'(e.cout));
          check($sformatf("sw%0d_ovf", g), 64'(swb.ovf), 64'(e.ovf));
          check($sformatf("sw%0d_latency", g), 64'(cyc - e.acc), 64'(SW));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run exceeded time limit, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.cin      = 1'b0;
    bus.sub      = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_sum", 64'(bus.sum), 64'(0));
    check("rst_cout", 64'(bus.cout), 64'(0));
    check("rst_ovf", 64'(bus.ovf), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;

    // Directed corner cases, exact latency, carry crossing every segment
    send(32'hFFFF, 32'h0001, 1'b0, 1'b0);
    send(32'h8000, 32'h0001, 1'b0, 1'b1);
    send(32'h0000, 32'h0001, 1'b0, 1'b1);
    send(32'h7FFF, 32'h0001, 1'b0, 1'b0);
    send(32'hFFFF, 32'h0000, 1'b1, 1'b0);
    send(32'h0000, 32'h0000, 1'b1, 1'b1);
    for (int k = 1; k <= S; k++) send((32'd1 << (k * (N / S))) - 32'd1, 32'h0001, 1'b0, 1'b0);
    drain();

    // 100 back-to-back random beats, out_ready held high
    for (int i = 0; i < 100; i++)
      send($urandom & 32'hFFFF, $urandom & 32'hFFFF, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain();

    // Random backpressure and input gaps
    chk_lat_mode = 1'b0;
    ready_mode   = 2;
    for (int i = 0; i < 200; i++) begin
      send($urandom & 32'hFFFF, $urandom & 32'hFFFF, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    ready_mode = 1;
    drain();

    // Reset with three beats in flight, output stalled
    ready_mode = 0;
    send(32'h1234, 32'h4321, 1'b0, 1'b0);
    send(32'hAAAA, 32'h5555, 1'b1, 1'b0);
    send(32'h0F0F, 32'hF0F0, 1'b0, 1'b1);
    idle(2);
    @(negedge clk);
    check("pre_rst_valid", 64'(bus.out_valid), 64'(1));
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 64'(bus.out_valid), 64'(0));
    check("mid_rst_sum", 64'(bus.sum), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    ready_mode = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_no_emit", 64'(bus.out_valid), 64'(0));
    end
    @(posedge clk);
    #1;

    // Other configurations
    chk_lat_mode = 1'b1;
    sweep_go = 1'b1;
    w = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && w < 500) begin
      @(posedge clk);
      w++;
    end
    check("sweep_done", 64'({g_sweep[0].done, g_sweep[1].done, g_sweep[2].done}), 64'(3'b111));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
